stereo_sched: RTL

Stereo matrix scheduler for the FM radio back end. It pops one sample pair from the L+R and L-R FIFOs and time-shares a single signed add/subtract unit to form left = (L+R)+(L-R) and right = (L+R)-(L-R). It writes the two results to separate left and right output FIFOs, with independent back-pressure handling. A configuration input selects mono fallback, and a completed-pair counter is exposed for status.

---
 rtl/stereo_sched_if.sv | 49 ++++
 rtl/stereo_sched.sv | 101 ++++++++++
 2 files changed

// File: rtl/stereo_sched_if.sv
// Stereo scheduler bus: L+R / L-R input FIFO heads, left / right output FIFOs,
// mono select and completed-pair status.
interface stereo_sched_if #(
   parameter int unsigned DATA_SIZE  = 32,
   parameter int unsigned COUNT_SIZE = 32
);
   logic                  mono_en;
   logic [DATA_SIZE-1:0]  lpr_in_dout;
   logic                  lpr_in_empty;
   logic                  lpr_in_rd_en;
   logic [DATA_SIZE-1:0]  lmr_in_dout;
   logic                  lmr_in_empty;
   logic                  lmr_in_rd_en;
   logic [DATA_SIZE-1:0]  left_out_din;
   logic                  left_out_full;
   logic                  left_out_wr_en;
   logic [DATA_SIZE-1:0]  right_out_din;
   logic                  right_out_full;
   logic                  right_out_wr_en;
   logic [COUNT_SIZE-1:0] pair_count;

   // Scheduler side.
   modport master (
      input  mono_en,
      input  lpr_in_dout, lpr_in_empty,
      output lpr_in_rd_en,
      input  lmr_in_dout, lmr_in_empty,
      output lmr_in_rd_en,
      output left_out_din, left_out_wr_en,
      input  left_out_full,
      output right_out_din, right_out_wr_en,
      input  right_out_full,
      output pair_count
   );

   // FIFO / environment side.
   modport slave (
      output mono_en,
      output lpr_in_dout, lpr_in_empty,
      input  lpr_in_rd_en,
      output lmr_in_dout, lmr_in_empty,
      input  lmr_in_rd_en,
      input  left_out_din, left_out_wr_en,
      output left_out_full,
      input  right_out_din, right_out_wr_en,
      output right_out_full,
      input  pair_count
   );
endinterface

// File: rtl/stereo_sched.sv
// Stereo matrix scheduler: pops an (L+R, L-R) pair, forms left = a+b and right = a-b
// on one shared add/sub unit, and writes each result to its own FIFO under
// independent back-pressure. Mono mode passes L+R to both outputs.
module stereo_sched #(
   parameter int unsigned DATA_SIZE  = 32,
   parameter int unsigned COUNT_SIZE = 32
) (
   input logic            clock,
   input logic            reset,
   stereo_sched_if.master bus
);

   typedef enum logic [1:0] {StRead, StCalcL, StCalcR, StWrite} state_e;

   state_e                state_q;
   logic [DATA_SIZE-1:0]  a_q;
   logic [DATA_SIZE-1:0]  b_q;
   logic                  mono_q;
   logic [DATA_SIZE-1:0]  left_q;
   logic [DATA_SIZE-1:0]  right_q;
   logic                  l_done_q;
   logic                  r_done_q;
   logic [COUNT_SIZE-1:0] pair_count_q;

   logic                  pop;
   logic                  wr_l;
   logic                  wr_r;
   logic                  l_fin;
   logic                  r_fin;
   logic [DATA_SIZE-1:0]  sum;
   logic [DATA_SIZE-1:0]  res;

   // Handshakes and shared add/sub; strobes are held off while reset is asserted.
   always_comb begin
      pop   = reset && (state_q == StRead) && !bus.lpr_in_empty && !bus.lmr_in_empty;
      wr_l  = reset && (state_q == StWrite) && !l_done_q && !bus.left_out_full;
      wr_r  = reset && (state_q == StWrite) && !r_done_q && !bus.right_out_full;
      l_fin = l_done_q || wr_l;
      r_fin = r_done_q || wr_r;
      // Subtract only in CALC_R; wraps modulo 2^DATA_SIZE.
      sum   = (state_q == StCalcR) ? (a_q - b_q) : (a_q + b_q);
      res   = mono_q ? a_q : sum;
   end

   // Scheduler FSM with its operand, result and status registers.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= StRead;
         a_q          <= '0;
         b_q          <= '0;
         mono_q       <= 1'b0;
         left_q       <= '0;
         right_q      <= '0;
         l_done_q     <= 1'b0;
         r_done_q     <= 1'b0;
         pair_count_q <= '0;
      end else begin
         unique case (state_q)
            StRead: begin
               if (pop) begin
                  a_q      <= bus.lpr_in_dout;
                  b_q      <= bus.lmr_in_dout;
                  mono_q   <= bus.mono_en;
                  l_done_q <= 1'b0;
                  r_done_q <= 1'b0;
                  state_q  <= StCalcL;
               end
            end
            StCalcL: begin
               left_q  <= res;
               state_q <= StCalcR;
            end
            StCalcR: begin
               right_q <= res;
               state_q <= StWrite;
            end
            StWrite: begin
               if (wr_l) l_done_q <= 1'b1;
               if (wr_r) r_done_q <= 1'b1;
               if (l_fin && r_fin) begin
                  pair_count_q <= pair_count_q + COUNT_SIZE'(1);
                  state_q      <= StRead;
               end
            end
            default: state_q <= StRead;
         endcase
      end
   end

   // Both FIFOs always pop together; din is zero unless its write strobe is high.
   always_comb begin
      bus.lpr_in_rd_en    = pop;
      bus.lmr_in_rd_en    = pop;
      bus.left_out_wr_en  = wr_l;
      bus.right_out_wr_en = wr_r;
      bus.left_out_din    = wr_l ? left_q : '0;
      bus.right_out_din   = wr_r ? right_q : '0;
      bus.pair_count      = pair_count_q;
   end

endmodule
